// File: rtl/qnn_dense_arbiter.sv
// qnn_dense_arbiter: round-robin sharing of one qnn dense engine between
// N_REQ requesters. A granted requester owns the engine for the whole job:
// the arbiter issues eng_start, waits for eng_done (bounded by TIMEOUT),
// then returns a one-cycle req_done pulse to the owner.
//
// Optional feature macro: QNN_ARB_PERF_EN
//   defined   -> per-requester completed-job counters and a busy-cycle counter
//   undefined -> perf_jobs / perf_busy are tied to zero, no counter logic
module qnn_dense_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 65535,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0][1:0]       req_prec,
    output logic [N_REQ-1:0]            grant,
    output logic [IDW-1:0]              gnt_id,
    output logic [N_REQ-1:0]            req_done,
    output logic                        eng_start,
    output logic [1:0]                  eng_prec,
    input  logic                        eng_done,
    output logic                        busy,
    output logic                        err_timeout,
    output logic                        err_prec,
    output logic [N_REQ-1:0][15:0]      perf_jobs,
    output logic [31:0]                 perf_busy
);

    localparam int unsigned NR = N_REQ;
    localparam int          CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]    TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [1:0]  PREC_BIN     = 2'd2;
    localparam logic [1:0]  PREC_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t          state;
    logic [IDW-1:0]  last;
    logic [CW-1:0]   cnt;

    logic            win_valid;
    logic [IDW-1:0]  win_id;
    int unsigned     scan_idx;

    // Round-robin search: first asserted request after the previous owner.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int unsigned i = 1; i <= NR; i++) begin
            scan_idx = (32'(last) + i) % NR;
            if (!win_valid && req[IDW'(scan_idx)]) begin
                win_valid = 1'b1;
                win_id    = IDW'(scan_idx);
            end
        end
    end

    // Job sequencing FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            gnt_id      <= '0;
            req_done    <= '0;
            eng_start   <= 1'b0;
            eng_prec    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_prec    <= 1'b0;
            last        <= IDW'(N_REQ - 1);
            cnt         <= '0;
        end else begin
            req_done    <= '0;
            err_timeout <= 1'b0;
            err_prec    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        grant     <= ONE_HOT0 << win_id;
                        gnt_id    <= win_id;
                        busy      <= 1'b1;
                        eng_start <= 1'b1;
                        if (req_prec[win_id] == PREC_ILLEGAL) begin
                            eng_prec <= PREC_BIN;
                            err_prec <= 1'b1;
                        end else begin
                            eng_prec <= req_prec[win_id];
                        end
                        state <= S_START;
                    end
                end
                S_START: begin
                    eng_start <= 1'b0;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // eng_done is checked first so a done/timeout tie completes cleanly
                    if (eng_done) begin
                        req_done <= grant;
                        state    <= S_COMPLETE;
                    end else if (cnt == TMO_LAST) begin
                        req_done    <= grant;
                        err_timeout <= 1'b1;
                        state       <= S_COMPLETE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_COMPLETE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    last  <= gnt_id;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef QNN_ARB_PERF_EN
    // Performance counters: saturating per-requester job count, wrapping busy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_jobs <= '0;
            perf_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (req_done[i] && (perf_jobs[i] != 16'hFFFF)) begin
                    perf_jobs[i] <= perf_jobs[i] + 16'd1;
                end
            end
            if (busy) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`else
    assign perf_jobs = '0;
    assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_qnn_dense_arbiter.sv
// Directed, table-driven bench for qnn_dense_arbiter (N_REQ=4, TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_qnn_dense_arbiter;

    localparam int NRQ = 4;
    localparam int TMO = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NRQ-1:0]       req;
    logic [NRQ-1:0][1:0]  req_prec;
    logic [NRQ-1:0]       grant;
    logic [1:0]           gnt_id;
    logic [NRQ-1:0]       req_done;
    logic                 eng_start;
    logic [1:0]           eng_prec;
    logic                 eng_done;
    logic                 busy;
    logic                 err_timeout;
    logic                 err_prec;
    logic [NRQ-1:0][15:0] perf_jobs;
    logic [31:0]          perf_busy;

    qnn_dense_arbiter #(
        .N_REQ   (NRQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_prec    (req_prec),
        .grant       (grant),
        .gnt_id      (gnt_id),
        .req_done    (req_done),
        .eng_start   (eng_start),
        .eng_prec    (eng_prec),
        .eng_done    (eng_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_prec    (err_prec),
        .perf_jobs   (perf_jobs),
        .perf_busy   (perf_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] prec;
        int         delay;     // WAIT cycles before eng_done is sampled; -1 = never
        logic       stray;     // pulse eng_done while in START
        logic [1:0] exp_id;
        logic [1:0] exp_prec;
        logic       exp_perr;
        logic       exp_to;
    } vec_t;

    vec_t vecs[14];
    int   n_checks;
    int   n_errs;
    int   exp_jobs[NRQ];
    int   exp_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NRQ; i++) exp_jobs[i] = 0;
        exp_busy = 0;
    endtask

    task automatic check_perf();
`ifdef QNN_ARB_PERF_EN
        for (int i = 0; i < NRQ; i++) chk("perf_jobs", 64'(perf_jobs[i]), 64'(exp_jobs[i]));
        chk("perf_busy", 64'(perf_busy), 64'(exp_busy));
`else
        chk("perf_jobs_off", 64'(perf_jobs), 64'd0);
        chk("perf_busy_off", 64'(perf_busy), 64'd0);
`endif
    endtask

    // Runs one job from an IDLE falling edge to the IDLE falling edge after it.
    task automatic run_job(input vec_t v);
        int w;
        int c;
        int starts;
        int exp_c;
        logic [3:0] oh;
        oh = 4'b0001 << v.exp_id;
        req      = v.req;
        req_prec = v.prec;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!eng_start && w < 4);
        chk("grant_latency", 64'(w), 64'd1);
        chk("grant", 64'(grant), 64'(oh));
        chk("gnt_id", 64'(gnt_id), 64'(v.exp_id));
        chk("eng_prec", 64'(eng_prec), 64'(v.exp_prec));
        chk("busy_start", 64'(busy), 64'd1);
        chk("err_prec", 64'(err_prec), 64'(v.exp_perr));
        if (v.stray) eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("start_pulse_len", 64'(eng_start), 64'd0);
        chk("err_prec_len", 64'(err_prec), 64'd0);
        req_prec = ~v.prec;
        c = 0;
        starts = 0;
        do begin
            eng_done = (c == v.delay);
            @(negedge clk);
            c++;
            if (eng_start) starts++;
        end while (req_done == '0 && c < TMO + 4);
        eng_done = 1'b0;
        exp_c = (v.delay >= 0) ? v.delay + 1 : TMO;
        chk("done_latency", 64'(c), 64'(exp_c));
        chk("req_done", 64'(req_done), 64'(oh));
        chk("err_timeout", 64'(err_timeout), 64'(v.exp_to));
        chk("busy_complete", 64'(busy), 64'd1);
        chk("extra_start", 64'(starts), 64'd0);
        chk("eng_prec_hold", 64'(eng_prec), 64'(v.exp_prec));
        exp_jobs[v.exp_id]++;
        exp_busy += 2 + exp_c;
        @(negedge clk);
        chk("idle_after", 64'({busy, grant, req_done, err_timeout}), 64'd0);
    endtask

    initial begin
        vec_t rv;
        n_checks = 0;
        n_errs   = 0;
        clear_model();
        rst_n    = 1'b0;
        req      = '0;
        req_prec = '0;
        eng_done = 1'b0;

        //        req      prec         dly  st    id    prec  perr  to
        vecs[0]  = '{4'b0100, 8'b00_01_00_00, 10, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 8'b10_01_00_01,  0, 1'b0, 2'd3, 2'd2, 1'b0, 1'b0};
        vecs[2]  = '{4'b1111, 8'b10_01_00_01,  1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{4'b1111, 8'b10_01_00_01,  2, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 8'b10_01_00_01,  5, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{4'b1111, 8'b10_01_00_01,  3, 1'b1, 2'd3, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 8'b10_01_00_01,  0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0};
        vecs[7]  = '{4'b1111, 8'b10_01_00_01,  7, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1111, 8'b10_01_00_01,  1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0};
        vecs[9]  = '{4'b0010, 8'b00_00_00_00, -1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1};
        vecs[10] = '{4'b1010, 8'b01_00_00_00,  4, 1'b0, 2'd3, 2'd1, 1'b0, 1'b0};
        vecs[11] = '{4'b0001, 8'b00_00_00_01, 15, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0};
        vecs[12] = '{4'b0010, 8'b00_00_11_00,  4, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0};
        vecs[13] = '{4'b0100, 8'b00_10_00_00,  0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outs", 64'({grant, gnt_id, req_done, eng_start, eng_prec, busy, err_timeout, err_prec}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_job(vecs[i]);
        req = '0;
        check_perf();

        // Stray eng_done while idle must not start or complete anything.
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("stray_idle", 64'({busy, grant, req_done, eng_start, err_timeout}), 64'd0);
        @(negedge clk);
        chk("stray_idle_2", 64'({busy, grant, req_done, eng_start, err_timeout}), 64'd0);

        // Reset in the middle of WAIT aborts the job without a req_done.
        req      = 4'b0100;
        req_prec = 8'b00_01_00_00;
        @(negedge clk);
        chk("pre_reset_grant", 64'(grant), 64'b0100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outs", 64'({grant, gnt_id, req_done, eng_start, eng_prec, busy, err_timeout, err_prec}), 64'd0);
        clear_model();
        check_perf();
        rst_n = 1'b1;
        rv = '{4'b1001, 8'b00_00_00_00, 2, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        run_job(rv);
        req = '0;
        check_perf();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
